// File: rtl/chunked_addsub_if.sv
// Start/busy/done handshake and operand/result bundle for the chunked adder/subtractor.
// Master drives the request, slave (the datapath) returns status and result.
interface chunked_addsub_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ov;
   logic             z;

   modport master (
      output start, mode, a, b, ci,
      input  busy, done, sum, co, ov, z
   );

   modport slave (
      input  start, mode, a, b, ci,
      output busy, done, sum, co, ov, z
   );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit add/adc/sub/sbc computed CHUNK bits per clock,
// LSB chunk first, with the carry registered between chunks.
module chunked_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic            clk,
   input logic            reset,
   chunked_addsub_if.slave bus
);
   // state  | meaning
   // S_IDLE | waiting for start; result registers hold the last completion
   // S_RUN  | one chunk per cycle, chunk index k_q, inter-chunk carry in carry_q

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    base;
   logic [CHUNK:0]   chunk_sum;
   logic             last;
   logic             finish;
   logic             carry_msb;

   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             ov_q;
   logic             z_q;
   logic             done_q;

   always_comb begin
      base      = IW'(k_q) * IW'(CHUNK);
      chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_q};
   end

   assign last = (k_q == KW'(NCHUNK - 1));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      finish  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d = bus.a;
               // Subtraction is A + ~B + not-borrow, so CO reads as 1 = no borrow.
               b_d = bus.mode[1] ? ~bus.b : bus.b;
               case (bus.mode)
                  2'b00:   carry_d = 1'b0;
                  2'b10:   carry_d = 1'b1;
                  default: carry_d = bus.ci;
               endcase
               k_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            work_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
            carry_d               = chunk_sum[CHUNK];
            if (last) begin
               finish  = 1'b1;
               k_d     = '0;
               state_d = S_IDLE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The MSB lives in the last chunk, so its carry-in is recoverable from the sum bit.
   assign carry_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ work_d[WIDTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         z_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         done_q  <= finish;
         if (finish) begin
            sum_q <= work_d;
            co_q  <= carry_d;
            ov_q  <= carry_msb ^ chunk_sum[CHUNK];
            z_q   <= (work_d == '0);
         end
      end
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.co   = co_q;
   assign bus.ov   = ov_q;
   assign bus.z    = z_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: directed handshake/flag cases on 16/4, random ops on 16/4,
// 16/1, 16/16 and 8/4, all checked against a full-width arithmetic reference.
module tb_chunked_addsub;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic void ref_op(input int w, input logic [1:0] mode,
                                  input logic [15:0] a, input logic [15:0] b, input logic ci,
                                  output logic [15:0] sum, output logic co,
                                  output logic ov, output logic z);
      longint m, ua, ub, sa, sb, r, sr, c;
      m  = longint'(1) << w;
      ua = longint'(a) % m;
      ub = longint'(b) % m;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (!mode[1]) begin
         c  = mode[0] ? longint'(ci) : 0;
         r  = ua + ub + c;
         sr = sa + sb + c;
         co = (r >= m);
      end else begin
         c  = (mode[0] && !ci) ? 1 : 0;
         r  = ua - ub - c;
         sr = sa - sb - c;
         co = (r >= 0);
      end
      r = r % m;
      if (r < 0) r = r + m;
      sum = 16'(r);
      ov  = (sr < -(m / 2)) || (sr >= m / 2);
      z   = (r == 0);
   endfunction

   // Main instance, WIDTH=16 / CHUNK=4
   logic rst0;
   chunked_addsub_if #(.WIDTH(16)) bus0 ();
   chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));

   task automatic launch(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input bit scramble);
      bus0.mode  = m;
      bus0.a     = a;
      bus0.b     = b;
      bus0.ci    = c;
      bus0.start = 1'b1;
      @(posedge clk);
      #1;
      bus0.start = 1'b0;
      if (scramble) begin
         bus0.a    = 16'($urandom);
         bus0.b    = 16'($urandom);
         bus0.mode = 2'($urandom);
         bus0.ci   = 1'($urandom);
      end
   endtask

   // Called just after the accepting edge; returns on the negedge of the DONE cycle.
   task automatic wait_done(input string tag, input bit poke);
      int cyc = 0;
      int busy_bad = 0;
      int hold_bad = 0;
      logic [15:0] prev = bus0.sum;
      do begin
         @(negedge clk);
         cyc++;
         if (!bus0.done && !bus0.busy) busy_bad++;
         if (!bus0.done && bus0.sum !== prev) hold_bad++;
         if (!bus0.done) begin
            bus0.start = poke && (cyc == 1 || cyc == 2);
            if (bus0.start) begin
               bus0.a    = 16'($urandom);
               bus0.b    = 16'($urandom);
               bus0.mode = 2'($urandom);
            end
         end
      end while (!bus0.done && cyc < 100);
      bus0.start = 1'b0;
      check({tag, "_latency"}, 32'(cyc - 1), 32'd4);
      check({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
      check({tag, "_sum_hold"}, 32'(hold_bad), 32'd0);
      check({tag, "_busy_done"}, 32'(bus0.busy), 32'd0);
   endtask

   task automatic check_res(input string tag, input logic [15:0] es, input logic eco,
                            input logic eov, input logic ez);
      check({tag, "_sum"}, 32'(bus0.sum), 32'(es));
      check({tag, "_co"}, 32'(bus0.co), 32'(eco));
      check({tag, "_ov"}, 32'(bus0.ov), 32'(eov));
      check({tag, "_z"}, 32'(bus0.z), 32'(ez));
   endtask

   task automatic check_pulse(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus0.done), 32'd0);
      check({tag, "_idle_after"}, 32'(bus0.busy), 32'd0);
   endtask

   // Parameter sweep instances
   localparam int SW_W [3] = '{16, 16, 8};
   localparam int SW_C [3] = '{1, 16, 4};
   logic [2:0] sweep_done = 3'b000;

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int W  = SW_W[g];
      localparam int C  = SW_C[g];
      localparam int NC = W / C;
      logic rst_s;
      chunked_addsub_if #(.WIDTH(W)) sbus ();
      chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .reset(rst_s), .bus(sbus));

      initial begin
         logic [15:0] ra, rb, es, mask;
         logic [1:0]  rm;
         logic        rc, eco, eov, ez;
         int          cyc;
         mask       = 16'((longint'(1) << W) - 1);
         rst_s      = 1'b1;
         sbus.start = 1'b0;
         sbus.mode  = 2'b00;
         sbus.a     = '0;
         sbus.b     = '0;
         sbus.ci    = 1'b0;
         repeat (3) @(negedge clk);
         rst_s = 1'b0;
         for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom) & mask;
            rb = 16'($urandom) & mask;
            if (n % 8 == 0) rb = mask - ra;
            rm = 2'($urandom);
            rc = 1'($urandom);
            @(negedge clk);
            sbus.a     = W'(ra);
            sbus.b     = W'(rb);
            sbus.mode  = rm;
            sbus.ci    = rc;
            sbus.start = 1'b1;
            @(posedge clk);
            #1;
            sbus.start = 1'b0;
            sbus.a     = W'($urandom);
            sbus.b     = W'($urandom);
            cyc = 0;
            do begin
               @(negedge clk);
               cyc++;
            end while (!sbus.done && cyc < 100);
            ref_op(W, rm, ra, rb, rc, es, eco, eov, ez);
            check($sformatf("sw%0d_lat", g), 32'(cyc - 1), 32'(NC));
            check($sformatf("sw%0d_sum", g), 32'(sbus.sum), 32'(es));
            check($sformatf("sw%0d_co", g), 32'(sbus.co), 32'(eco));
            check($sformatf("sw%0d_ov", g), 32'(sbus.ov), 32'(eov));
            check($sformatf("sw%0d_z", g), 32'(sbus.z), 32'(ez));
         end
         sweep_done[g] = 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] ra, rb, es;
      logic [1:0]  rm;
      logic        rc, eco, eov, ez;
      int          seen;

      rst0       = 1'b1;
      bus0.start = 1'b0;
      bus0.mode  = 2'b00;
      bus0.a     = '0;
      bus0.b     = '0;
      bus0.ci    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus0.busy), 32'd0);
      check("rst_done", 32'(bus0.done), 32'd0);
      check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst0 = 1'b0;

      @(negedge clk);
      launch(2'b00, 16'h1234, 16'h0FCD, 1'b0, 1'b1);
      wait_done("add", 1'b0);
      check_res("add", 16'h2201, 1'b0, 1'b0, 1'b0);
      check_pulse("add");

      @(negedge clk);
      launch(2'b01, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
      wait_done("adc", 1'b0);
      check_res("adc", 16'h0000, 1'b1, 1'b0, 1'b1);
      check_pulse("adc");

      @(negedge clk);
      launch(2'b10, 16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done("sub", 1'b0);
      check_res("sub", 16'h7FFF, 1'b1, 1'b1, 1'b0);
      check_pulse("sub");

      @(negedge clk);
      launch(2'b11, 16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_done("sbc", 1'b0);
      check_res("sbc", 16'hFFFD, 1'b0, 1'b0, 1'b0);
      check_pulse("sbc");

      // START pulses while busy must be dropped, not queued
      @(negedge clk);
      launch(2'b00, 16'h0100, 16'h0200, 1'b0, 1'b0);
      wait_done("ignore", 1'b1);
      check_res("ignore", 16'h0300, 1'b0, 1'b0, 1'b0);
      check_pulse("ignore");

      // START in the DONE cycle is accepted
      @(negedge clk);
      launch(2'b10, 16'h0010, 16'h0003, 1'b0, 1'b0);
      wait_done("b2b_first", 1'b0);
      check_res("b2b_first", 16'h000D, 1'b1, 1'b0, 1'b0);
      launch(2'b00, 16'h0001, 16'h0001, 1'b0, 1'b1);
      wait_done("b2b_second", 1'b0);
      check_res("b2b_second", 16'h0002, 1'b0, 1'b0, 1'b0);
      check_pulse("b2b_second");

      // Reset during the second RUN cycle aborts silently
      @(negedge clk);
      launch(2'b00, 16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      check("abort_busy", 32'(bus0.busy), 32'd0);
      check("abort_done", 32'(bus0.done), 32'd0);
      check_res("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus0.done) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      launch(2'b00, 16'h4000, 16'h4000, 1'b0, 1'b0);
      wait_done("post_rst", 1'b0);
      check_res("post_rst", 16'h8000, 1'b0, 1'b1, 1'b0);

      for (int n = 0; n < 30; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rm = 2'($urandom);
         rc = 1'($urandom);
         @(negedge clk);
         launch(rm, ra, rb, rc, 1'b1);
         wait_done($sformatf("rnd%0d", n), n[0]);
         ref_op(16, rm, ra, rb, rc, es, eco, eov, ez);
         check_res($sformatf("rnd%0d", n), es, eco, eov, ez);
      end

      for (int i = 0; i < 5000 && sweep_done != 3'b111; i++) @(negedge clk);
      check("sweep_complete", 32'(sweep_done), 32'h7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Parametrised multi-cycle adder/subtractor for the Slipstream datapath. It generalises the 4-bit carry-in/carry-out adder cell to WIDTH bits by processing CHUNK bits per clock, LSB chunk first, with the carry registered between chunks. It supports four arithmetic modes and produces carry, signed-overflow and zero flags. A START/BUSY/DONE handshake lets it share a slow arithmetic slot in the blitter/DSP address paths without a full-width carry chain.

## Interface
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits processed per cycle; must divide WIDTH. NCHUNK = WIDTH/CHUNK.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- MODE  in  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBC.
- A  in  WIDTH  operand A; sampled on the accepting edge.
- B  in  WIDTH  operand B; sampled on the accepting edge.
- CI  in  1  carry in (ADC) or not-borrow in (SBC); sampled on the accepting edge.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse; result valid.
- SUM  out  WIDTH  result.
- CO  out  1  carry out; for SUB/SBC, 1 = no borrow.
- OV  out  1  signed two's-complement overflow.
- Z  out  1  SUM == 0.

## Operation
- States: IDLE, RUN. Chunk index counter k: 0..NCHUNK-1.
- IDLE with START=1:
  - Latch A.
  - Latch B (inverted for SUB/SBC).
  - Latch the initial carry: ADD 0, ADC CI, SUB 1, SBC CI.
  - Set k=0 and go to RUN.
- RUN, each cycle:
  - Compute chunk k: A[k] + B'[k] + carry, CHUNK+1 bits wide.
  - Write the low CHUNK bits into the internal working register.
  - Register the top bit as the carry; increment k.
- Last chunk (k = NCHUNK-1), in the same edge:
  - SUM ← the full working result (including the final chunk).
  - CO ← final carry.
  - OV ← carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Z ← (result == 0).
  - DONE ← 1; return to IDLE.
- SUM/CO/OV/Z are updated only on completion and hold until the next completion. No partial results are visible.
- START while BUSY=1 is ignored; no queueing.
- Reset mid-operation: abort and return to IDLE. The aborted operation produces no DONE.
- NCHUNK=1 is legal (single-cycle registered adder). CHUNK=1 is legal (bit-serial).
- Arithmetic is modulo 2^WIDTH. Signed/unsigned interpretation is left to the consumer via CO/OV.

## Timing
- Reset values: BUSY=0, DONE=0, SUM=0, CO=0, OV=0, Z=0, state IDLE, k=0, carry=0.
- START accepted at edge t (BUSY=0 before t):
  - BUSY=1 from t to t+NCHUNK.
  - Result registered and DONE=1 after edge t+NCHUNK.
  - BUSY=0 in the DONE cycle.
- Latency is NCHUNK cycles (WIDTH=16, CHUNK=4: DONE 4 cycles after the accepting edge).
- DONE is high for exactly one cycle.
- Back-to-back: START=1 during the DONE cycle is accepted. Throughput is one op per NCHUNK cycles.
- Operands and MODE may change freely after the accepting edge.
- RESET takes priority over START on the same edge.

## Test plan
- ADD A=0x1234, B=0x0FCD -> SUM=0x2201, CO=0, OV=0, Z=0. DONE exactly 4 cycles after the START edge, single pulse; BUSY high for the 4 cycles before it.
- ADC A=0xFFFF, B=0x0000, CI=1 -> SUM=0x0000, CO=1, Z=1, OV=0. Carry ripples through all 4 chunk registers.
- SUB A=0x8000, B=0x0001 -> SUM=0x7FFF, CO=1, OV=1. SBC A=0x0005, B=0x0007, CI=0 -> SUM=0xFFFD, CO=0, OV=0.
- Handshake:
  - Change A/B/MODE after acceptance: result unaffected.
  - START pulses while BUSY: ignored.
  - START in the DONE cycle: second op (ADD 0x0001+0x0001 -> 0x0002) completes 4 cycles later.
  - Prior SUM holds until that completion.
- RESET asserted at the 2nd RUN cycle -> next cycle BUSY=0, SUM/flags=0. DONE never pulses for the aborted op; a fresh START then completes normally.
- Parameter sweep WIDTH=16 with CHUNK=1 (latency 16) and CHUNK=16 (latency 1), plus WIDTH=8/CHUNK=4. Run random A/B/MODE/CI and compare SUM/CO/OV/Z against a full-width reference model.
